// File: rtl/sieve_pkg.sv
// Shared types and defaults for the BitSieve flip-commit stage.
// Optional statistics counters in the top level are enabled with the
// SIEVE_STATS_EN macro.
package sieve_pkg;

    localparam int N_DEF        = 1024;
    localparam int IDX_W_DEF    = 10;
    localparam int OFF_W_DEF    = 16;
    localparam int OFF_STEP_DEF = 1;
    localparam int ITER_W_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EVAL   = 3'd1,
        FLIP   = 3'd2,
        ESCAPE = 3'd3,
        NEXT   = 3'd4
    } state_e;

    // a + b clamped to max_v; the 33-bit sum keeps the carry so a large
    // step can never wrap past the ceiling.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/sieve_flip_commit_escape_offset_acc.sv
// Saturating escape-offset accumulator: clear has priority over step, and
// each step adds OFF_STEP without ever wrapping past 2^OFF_W-1.
module escape_offset_acc
    import sieve_pkg::*;
#(
    parameter int OFF_W    = OFF_W_DEF,
    parameter int OFF_STEP = OFF_STEP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             step_i,
    output logic [OFF_W-1:0] offset_o
);

    localparam logic [31:0] MAX_V = 32'((64'd1 << OFF_W) - 64'd1);

    logic [OFF_W-1:0] offset_q;
    logic [OFF_W-1:0] offset_d;

    // Next offset: clear wins, otherwise a saturating step.
    always_comb begin
        offset_d = offset_q;
        if (clr_i) begin
            offset_d = '0;
        end else if (step_i) begin
            offset_d = OFF_W'(sat_add(32'(offset_q), 32'(OFF_STEP), MAX_V));
        end
    end

    // Offset register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end

    assign offset_o = offset_q;

endmodule

// File: rtl/sieve_flip_commit.sv
// Flip-commit stage of the BitSieve annealer. Samples the tournament
// selector's winner once per iteration; a winner is committed into the spin
// vector and broadcast to the field updaters, no winner raises the escape
// offset. Owns the spin vector, escape offset and iteration budget.
// Define SIEVE_STATS_EN to add the flip_cnt / escape_cnt counters.
//
// Flip broadcast handshake: flip_valid rises the cycle after a winning
// strobe and stays high, with flip_index stable, until a rising clock edge
// sees flip_valid && flip_ready. That edge commits the flip; flip_valid is
// low from the next cycle.
module sieve_flip_commit
    import sieve_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int OFF_W    = OFF_W_DEF,
    parameter int OFF_STEP = OFF_STEP_DEF,
    parameter int ITER_W   = ITER_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iters,
    input  logic [N-1:0]      spin_init,
    input  logic              sel_strobe,
    input  logic [IDX_W-1:0]  final_index,
    input  logic              final_valid,
    output logic              rand_adv,
    output logic              flip_valid,
    output logic [IDX_W-1:0]  flip_index,
    input  logic              flip_ready,
    output logic [N-1:0]      spin_q,
    output logic [OFF_W-1:0]  offset_q,
    output logic              busy,
`ifdef SIEVE_STATS_EN
    output logic [ITER_W-1:0] flip_cnt,
    output logic [ITER_W-1:0] escape_cnt,
`endif
    output logic              done
);

    localparam logic [N-1:0] BIT0 = {{(N-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]      spin_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              flip_valid_q, flip_valid_d;
    logic              busy_q, busy_d;
    logic              rand_adv_q, rand_adv_d;
    logic              done_q, done_d;

    logic start_go;
    logic strobe_hit;
    logic winner_ok;
    logic handshake;

    // An index outside the spin vector is treated as no winner.
    assign winner_ok  = final_valid && (32'(final_index) < 32'(N));
    assign start_go   = (state_q == IDLE) && start;
    assign strobe_hit = (state_q == EVAL) && sel_strobe;
    assign handshake  = (state_q == FLIP) && flip_valid_q && flip_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && (max_iters != '0)) state_d = EVAL;
            EVAL:    if (sel_strobe) state_d = winner_ok ? FLIP : ESCAPE;
            FLIP:    if (flip_valid_q && flip_ready) state_d = NEXT;
            ESCAPE:  state_d = NEXT;
            NEXT:    state_d = (cnt_q <= ITER_W'(1)) ? IDLE : EVAL;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; the pulse/level outputs are
    // registered, so they are derived from the upcoming state.
    always_comb begin
        cnt_d  = cnt_q;
        spin_d = spin_q;
        idx_d  = idx_q;
        if (start_go) begin
            cnt_d  = max_iters;
            spin_d = spin_init;
        end
        if (strobe_hit && winner_ok) begin
            idx_d = final_index;
        end
        if (handshake) begin
            spin_d = spin_q ^ (BIT0 << idx_q);
        end
        if (state_q == NEXT) begin
            cnt_d = cnt_q - ITER_W'(1);
        end
        flip_valid_d = (state_d == FLIP);
        busy_d       = (state_d != IDLE);
        rand_adv_d   = strobe_hit;
        done_d       = (start_go && (max_iters == '0)) ||
                       ((state_q == NEXT) && (cnt_q <= ITER_W'(1)));
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            spin_q       <= '0;
            idx_q        <= '0;
            flip_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            rand_adv_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            spin_q       <= spin_d;
            idx_q        <= idx_d;
            flip_valid_q <= flip_valid_d;
            busy_q       <= busy_d;
            rand_adv_q   <= rand_adv_d;
            done_q       <= done_d;
        end
    end

    // Escape offset: cleared on start and on every committed flip.
    escape_offset_acc #(
        .OFF_W    (OFF_W),
        .OFF_STEP (OFF_STEP)
    ) u_offset (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (start_go || handshake),
        .step_i   (state_q == ESCAPE),
        .offset_o (offset_q)
    );

    assign flip_valid = flip_valid_q;
    assign flip_index = idx_q;
    assign busy       = busy_q;
    assign rand_adv   = rand_adv_q;
    assign done       = done_q;

`ifdef SIEVE_STATS_EN
    logic [ITER_W-1:0] flip_cnt_q;
    logic [ITER_W-1:0] escape_cnt_q;

    // Saturating run statistics, cleared on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flip_cnt_q   <= '0;
            escape_cnt_q <= '0;
        end else if (start_go) begin
            flip_cnt_q   <= '0;
            escape_cnt_q <= '0;
        end else begin
            if (handshake && (flip_cnt_q != '1)) begin
                flip_cnt_q <= flip_cnt_q + ITER_W'(1);
            end
            if (strobe_hit && !winner_ok && (escape_cnt_q != '1)) begin
                escape_cnt_q <= escape_cnt_q + ITER_W'(1);
            end
        end
    end

    assign flip_cnt   = flip_cnt_q;
    assign escape_cnt = escape_cnt_q;
`endif

endmodule

// File: tb/tb_sieve_flip_commit.sv
// Bench for sieve_flip_commit: a default instance plus a 4-bit-offset
// instance sharing the same stimulus, checked against a transaction-level
// model of the spin vector, escape offset and pulse counts.
module tb_sieve_flip_commit;

    localparam int N      = 1024;
    localparam int IDX_W  = 10;
    localparam int OFF_W  = 16;
    localparam int ITER_W = 16;
    localparam int MAX16  = 65535;
    localparam int MAX4   = 15;

    // clock / reset and shared inputs
    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [ITER_W-1:0] max_iters = '0;
    logic [N-1:0]      spin_init = '0;
    logic              sel_strobe = 1'b0;
    logic [IDX_W-1:0]  final_index = '0;
    logic              final_valid = 1'b0;
    logic              flip_ready = 1'b0;

    // outputs of the default instance
    logic              rand_adv, flip_valid, busy, done;
    logic [IDX_W-1:0]  flip_index;
    logic [N-1:0]      spin_q;
    logic [OFF_W-1:0]  offset_q;

    // outputs of the narrow-offset instance
    logic              rand_adv4, flip_valid4, busy4, done4;
    logic [IDX_W-1:0]  flip_index4;
    logic [N-1:0]      spin4;
    logic [3:0]        offset4;

    always #5 clk = ~clk;

    sieve_flip_commit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .max_iters(max_iters),
        .spin_init(spin_init), .sel_strobe(sel_strobe), .final_index(final_index),
        .final_valid(final_valid), .rand_adv(rand_adv), .flip_valid(flip_valid),
        .flip_index(flip_index), .flip_ready(flip_ready), .spin_q(spin_q),
        .offset_q(offset_q), .busy(busy), .done(done)
    );

    sieve_flip_commit #(.OFF_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .max_iters(max_iters),
        .spin_init(spin_init), .sel_strobe(sel_strobe), .final_index(final_index),
        .final_valid(final_valid), .rand_adv(rand_adv4), .flip_valid(flip_valid4),
        .flip_index(flip_index4), .flip_ready(flip_ready), .spin_q(spin4),
        .offset_q(offset4), .busy(busy4), .done(done4)
    );

    // reference model and scoreboard
    logic [N-1:0]     m_spin;
    int               m_off, m_off4, m_left, m_adv, m_done;
    logic [IDX_W-1:0] exp_q[$];
    int               n_chk = 0;
    int               n_err = 0;
    int               adv_cnt = 0;
    int               done_cnt = 0;

    // pulse monitor: registered outputs are sampled mid-cycle
    always @(negedge clk) begin
        if (rand_adv) adv_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_spin(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        int first;
        first = 0;
        for (int i = N - 1; i >= 0; i--) if (obs[i] !== exp[i]) first = i;
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: first differing bit %0d observed=%b expected=%b",
                   tag, first, obs[first], exp[first]);
        end
    endtask

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] v;
        for (int w = 0; w < N / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int sat_inc(input int v, input int max_v);
        return (v + 1 > max_v) ? max_v : v + 1;
    endfunction

    task automatic model_reset();
        m_spin = '0;
        m_off  = 0;
        m_off4 = 0;
        m_left = 0;
        exp_q.delete();
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic start_run(input int iters, input logic [N-1:0] init);
        start     = 1'b1;
        max_iters = ITER_W'(iters);
        spin_init = init;
        m_spin    = init;
        m_off     = 0;
        m_off4    = 0;
        m_left    = iters;
        @(negedge clk);
        start     = 1'b0;
        max_iters = ITER_W'($urandom);
        spin_init = rand_vec();
        chk_spin("start_spin", spin_q, m_spin);
        chk("start_offset", 64'(offset_q), 64'(m_off));
        if (iters == 0) begin
            m_done++;
            chk("zero_done", 64'(done), 64'd1);
            chk("zero_busy", 64'(busy), 64'd0);
            @(negedge clk);
            chk("zero_done_drop", 64'(done), 64'd0);
            chk("zero_busy_after", 64'(busy), 64'd0);
        end else begin
            chk("start_busy", 64'(busy), 64'd1);
            chk("start_fv", 64'(flip_valid), 64'd0);
        end
    endtask

    // One iteration from EVAL: win selects winner/no winner, stall is the
    // number of backpressure cycles before flip_ready rises.
    task automatic do_iter(input bit win, input logic [IDX_W-1:0] idx, input int stall);
        sel_strobe  = 1'b1;
        final_valid = win;
        final_index = idx;
        flip_ready  = (stall == 0);
        @(negedge clk);
        sel_strobe  = 1'b0;
        final_valid = 1'($urandom);
        final_index = IDX_W'($urandom);
        m_adv++;
        chk("rand_adv", 64'(rand_adv), 64'd1);
        if (win) begin
            exp_q.push_back(idx);
            chk("fv_rise", 64'(flip_valid), 64'd1);
            chk_spin("spin_hold", spin_q, m_spin);
            for (int s = 0; s < stall; s++) begin
                sel_strobe  = 1'($urandom_range(0, 1));
                final_valid = 1'b1;
                final_index = IDX_W'($urandom);
                @(negedge clk);
                sel_strobe = 1'b0;
                chk("bp_fv", 64'(flip_valid), 64'd1);
                chk("bp_idx", 64'(flip_index), 64'(idx));
                chk("bp_adv", 64'(rand_adv), 64'd0);
                chk_spin("bp_spin", spin_q, m_spin);
            end
            chk("flip_index", 64'(flip_index), 64'(exp_q.pop_front()));
            flip_ready = 1'b1;
            @(negedge clk);
            flip_ready = 1'b0;
            m_spin[idx] = ~m_spin[idx];
            m_off  = 0;
            m_off4 = 0;
            chk_spin("commit_spin", spin_q, m_spin);
            chk_spin("commit_spin4", spin4, m_spin);
            chk("commit_offset", 64'(offset_q), 64'(m_off));
            chk("commit_offset4", 64'(offset4), 64'(m_off4));
            chk("commit_fv_drop", 64'(flip_valid), 64'd0);
        end else begin
            flip_ready = 1'b0;
            chk("esc_fv", 64'(flip_valid), 64'd0);
            @(negedge clk);
            m_off  = sat_inc(m_off, MAX16);
            m_off4 = sat_inc(m_off4, MAX4);
            chk("esc_offset", 64'(offset_q), 64'(m_off));
            chk("esc_offset4", 64'(offset4), 64'(m_off4));
            chk_spin("esc_spin", spin_q, m_spin);
        end
        @(negedge clk);
        m_left--;
        if (m_left == 0) begin
            m_done++;
            chk("end_done", 64'(done), 64'd1);
            chk("end_busy", 64'(busy), 64'd0);
        end else begin
            chk("mid_done", 64'(done), 64'd0);
            chk("mid_busy", 64'(busy), 64'd1);
        end
    endtask

    task automatic check_counts();
        #1;
        chk("adv_count", 64'(adv_cnt), 64'(m_adv));
        chk("done_count", 64'(done_cnt), 64'(m_done));
    endtask

    initial begin
        m_adv  = 0;
        m_done = 0;
        model_reset();

        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rand_adv", 64'(rand_adv), 64'd0);
        chk("rst_fv", 64'(flip_valid), 64'd0);
        chk("rst_idx", 64'(flip_index), 64'd0);
        chk_spin("rst_spin", spin_q, '0);
        chk("rst_offset", 64'(offset_q), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // three winners, index 5 twice and the top index
        start_run(3, '0);
        do_iter(1'b1, 10'd5, 0);
        do_iter(1'b1, 10'd5, 0);
        do_iter(1'b1, 10'd1023, 0);
        chk("t1_bit5", 64'(spin_q[5]), 64'd0);
        chk("t1_bit1023", 64'(spin_q[1023]), 64'd1);
        check_counts();

        // strobe while idle is ignored
        @(negedge clk);
        sel_strobe  = 1'b1;
        final_valid = 1'b1;
        @(negedge clk);
        sel_strobe = 1'b0;
        chk("idle_strobe_busy", 64'(busy), 64'd0);
        chk("idle_strobe_fv", 64'(flip_valid), 64'd0);
        chk("idle_strobe_adv", 64'(rand_adv), 64'd0);

        // no-winner path
        start_run(4, rand_vec());
        repeat (4) do_iter(1'b0, 10'd0, 0);
        check_counts();

        // offset cleared by a committed flip
        @(negedge clk);
        start_run(3, rand_vec());
        do_iter(1'b0, 10'd0, 0);
        do_iter(1'b0, 10'd0, 0);
        do_iter(1'b1, 10'd7, 0);

        // backpressure
        start_run(2, rand_vec());
        do_iter(1'b1, 10'd300, 5);
        do_iter(1'b0, 10'd0, 0);

        // saturation of the narrow offset, then a zero-length run
        start_run(20, rand_vec());
        repeat (20) do_iter(1'b0, 10'd0, 0);
        chk("sat_offset16", 64'(offset_q), 64'd20);
        chk("sat_offset4", 64'(offset4), 64'd15);
        start_run(0, rand_vec());
        check_counts();

        // async reset while a flip is stalled
        @(negedge clk);
        start_run(3, rand_vec());
        sel_strobe  = 1'b1;
        final_valid = 1'b1;
        final_index = 10'd9;
        flip_ready  = 1'b0;
        @(negedge clk);
        sel_strobe = 1'b0;
        m_adv++;
        chk("pre_rst_fv", 64'(flip_valid), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_fv", 64'(flip_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk_spin("mid_rst_spin", spin_q, '0);
        chk("mid_rst_offset", 64'(offset_q), 64'd0);
        chk("mid_rst_idx", 64'(flip_index), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        start_run(2, rand_vec());
        do_iter(1'b1, 10'd9, 0);
        do_iter(1'b0, 10'd0, 1);
        check_counts();

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            int iters;
            @(negedge clk);
            iters = $urandom_range(1, 6);
            start_run(iters, rand_vec());
            for (int k = 0; k < iters; k++) begin
                do_iter(1'($urandom_range(0, 1)), IDX_W'($urandom), $urandom_range(0, 3));
            end
            check_counts();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sieve_flip_commit.md
Name: sieve_flip_commit

Overview:
- Sits directly downstream of the 1024-leaf randomized tournament selector in the BitSieve annealer.
- Each iteration it samples the selector's winner. With a winner, it commits that spin flip and broadcasts the flip to the local-field updaters through a valid/ready handshake. With no winner, it raises the escape energy offset.
- It owns the spin state vector, the escape offset and the iteration budget.

Parameters:
- N, 1024, number of spins (must equal the selector leaf count).
- IDX_W, 10, winner index width, log2(N).
- OFF_W, 16, escape offset width.
- OFF_STEP, 1, offset increment per no-winner iteration.
- ITER_W, 16, iteration counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- max_iters  in  ITER_W  iteration budget, latched on start.
- spin_init  in  N  initial spin vector, latched on start.
- sel_strobe  in  1  selector output settled; sample final_index/final_valid this cycle.
- final_index  in  IDX_W  selector winner index.
- final_valid  in  1  selector found at least one accepted candidate.
- rand_adv  out  1  one-cycle pulse telling the RNG to advance rand_bits.
- flip_valid  out  1  flip broadcast valid.
- flip_index  out  IDX_W  index being flipped.
- flip_ready  in  1  field updaters accept the flip.
- spin_q  out  N  current spin state.
- offset_q  out  OFF_W  current escape offset, fed back to the acceptance logic.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; spin_q=0, offset_q=0, flip_index=0, flip_valid=0, rand_adv=0, done=0, busy=0; iteration counter=0.
- States: IDLE, EVAL, FLIP, ESCAPE, NEXT. flip_valid, busy, rand_adv and done are all registered.
- IDLE, start=1:
  - Latch spin_init into spin_q and max_iters into the counter; clear offset_q.
  - If max_iters==0, stay in IDLE and pulse done next cycle.
  - Otherwise go to EVAL.
- EVAL: wait for sel_strobe. On the strobe edge:
  - final_valid=1: capture final_index into flip_index and go to FLIP.
  - final_valid=0: go to ESCAPE.
  - In both cases pulse rand_adv for exactly one cycle, in the cycle after the strobe.
  - sel_strobe outside EVAL is ignored.
- FLIP:
  - flip_valid=1 and flip_index is held stable until flip_ready.
  - On the handshake cycle (flip_valid && flip_ready): toggle spin_q[flip_index], clear offset_q to 0, go to NEXT.
  - flip_valid drops the cycle after the handshake.
  - Latency: strobe at edge t gives flip_valid=1 from t+1; with flip_ready tied high, spin_q changes at edge t+1.
- ESCAPE (one cycle): offset_q += OFF_STEP, saturating at 2^OFF_W-1 (no wrap). Go to NEXT.
- NEXT:
  - Decrement the iteration counter.
  - If the count reaches 0, go to IDLE and pulse done for one cycle.
  - Otherwise return to EVAL.
- start while busy is ignored; max_iters and spin_init changes while busy are ignored.
- final_index >= N cannot occur for N=1024. For smaller N, an out-of-range index is treated as no winner (ESCAPE).
- Reset mid-run:
  - Immediate return to IDLE with all outputs at reset values.
  - A flip handshake in progress is dropped; the field updaters must be reset together with this block.

Optional Feature:
- Macro SIEVE_STATS_EN.
- When defined, adds outputs flip_cnt[ITER_W] and escape_cnt[ITER_W]:
  - both cleared on start and on reset;
  - flip_cnt increments on each flip handshake;
  - escape_cnt increments on each ESCAPE entry;
  - both saturate at their maximum value.
- When undefined: the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Package sieve_pkg: state enum (IDLE, EVAL, FLIP, ESCAPE, NEXT), N/IDX_W/OFF_W defaults, saturating-add helper function.
- One natural sub-module, escape_offset_acc: a saturating accumulator with clear and step controls.
- The FSM, spin register and iteration counter stay in the top level.

Test Plan:
- Reset: with rst_n=0, all outputs read 0. Start with max_iters=3, spin_init=0, then three strobes with final_valid=1 and indices 5, 5, 1023, flip_ready=1 → spin_q[5]=0 (flipped twice), spin_q[1023]=1, exactly 3 rand_adv pulses, done pulses once, busy falls.
- No-winner path: max_iters=4, all strobes final_valid=0, OFF_STEP=1 → offset_q steps 1,2,3,4; spin_q unchanged; flip_valid never asserted.
- Offset clear: two escapes (offset_q=2), then a winner at index 7 → offset_q=0 on the handshake edge, spin_q[7] toggled on that same edge.
- Backpressure: hold flip_ready=0 for 5 cycles in FLIP → flip_valid and flip_index stay stable, spin_q unchanged, extra sel_strobe pulses ignored; the flip commits on the cycle flip_ready rises.
- Saturation: OFF_W=4, 20 consecutive escapes → offset_q stops at 15, no wrap. Also start with max_iters=0 → done pulse, busy stays 0.
- Async reset mid-FLIP with flip_ready=0 → flip_valid drops immediately, state IDLE, spin_q=0. A following start runs normally.
